// File: rtl/dma_bus_arbiter_if.sv
// Bus-side handshake bundle for dma_bus_arbiter.
// The master modport is the arbiter; the slave modport is the CPU/bus and DMA-engine side.
interface dma_bus_arbiter_if;
  logic       DMA_REQ;
  logic       CYCLE_ACTIVE;
  logic       _BG;
  logic       _BGACK_IN;
  logic       _AS_IN;
  logic [1:0] _DSACK_IN;
  logic       _STERM;
  logic       _BERR;
  logic       _BR;
  logic       _BGACK_O;
  logic       OWN_;
  logic       GRANTED;
  logic       BUS_ERR;

  modport master (
    input  DMA_REQ, CYCLE_ACTIVE, _BG, _BGACK_IN, _AS_IN, _DSACK_IN, _STERM, _BERR,
    output _BR, _BGACK_O, OWN_, GRANTED, BUS_ERR
  );

  modport slave (
    output DMA_REQ, CYCLE_ACTIVE, _BG, _BGACK_IN, _AS_IN, _DSACK_IN, _STERM, _BERR,
    input  _BR, _BGACK_O, OWN_, GRANTED, BUS_ERR
  );
endinterface

// File: rtl/dma_bus_arbiter.sv
// dma_bus_arbiter: requests the CPU bus, waits for it to go idle, owns it and releases it in order.
// Define TENURE_LIMIT_EN to compile in an 8-bit ownership tenure limit with a longer cooldown.
module dma_bus_arbiter (
  input  logic              SCLK,
  input  logic              _RST,
  dma_bus_arbiter_if.master bus
);
  localparam int unsigned CD_W = 2;
  // Cooldown loads N-1 so a held DMA_REQ re-requests exactly N edges after IDLE entry.
  localparam logic [CD_W-1:0] CD_NORMAL = CD_W'(1);
`ifdef TENURE_LIMIT_EN
  localparam int unsigned TEN_W = 8;
  localparam logic [CD_W-1:0]  CD_TENURE = CD_W'(3);
  localparam logic [TEN_W-1:0] TEN_MAX   = '1;
`endif

  typedef enum logic [2:0] {IDLE, REQ, WAIT_IDLE, OWN, REL} state_t;

  state_t          state_q, state_d;
  logic            br_q, br_d;
  logic            bgack_q, bgack_d;
  logic            own_q, own_d;
  logic            granted_q, granted_d;
  logic            bus_err_q, bus_err_d;
  logic            berr_block_q, berr_block_d;
  logic [CD_W-1:0] cool_q, cool_d;
  logic            bus_idle_c;
`ifdef TENURE_LIMIT_EN
  logic [TEN_W-1:0] tenure_q, tenure_d;
  logic             forced_q, forced_d;
  logic             tenure_hit_c;
`endif

  assign bus._BR      = br_q;
  assign bus._BGACK_O = bgack_q;
  assign bus.OWN_     = own_q;
  assign bus.GRANTED  = granted_q;
  assign bus.BUS_ERR  = bus_err_q;

  // Previous master has fully let go of the bus.
  assign bus_idle_c = bus._AS_IN && (bus._DSACK_IN == 2'b11) && bus._STERM && bus._BGACK_IN;

  always_ff @(posedge SCLK) begin
    if (!_RST) begin
      state_q      <= IDLE;
      br_q         <= 1'b1;
      bgack_q      <= 1'b1;
      own_q        <= 1'b1;
      granted_q    <= 1'b0;
      bus_err_q    <= 1'b0;
      berr_block_q <= 1'b0;
      cool_q       <= '0;
`ifdef TENURE_LIMIT_EN
      tenure_q     <= '0;
      forced_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      br_q         <= br_d;
      bgack_q      <= bgack_d;
      own_q        <= own_d;
      granted_q    <= granted_d;
      bus_err_q    <= bus_err_d;
      berr_block_q <= berr_block_d;
      cool_q       <= cool_d;
`ifdef TENURE_LIMIT_EN
      tenure_q     <= tenure_d;
      forced_q     <= forced_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    cool_d       = cool_q;
    berr_block_d = berr_block_q;
    granted_d    = 1'b0;
    bus_err_d    = 1'b0;
`ifdef TENURE_LIMIT_EN
    forced_d     = forced_q;
    tenure_hit_c = (tenure_q == TEN_MAX) && !bus.CYCLE_ACTIVE;
    if (state_q != OWN)           tenure_d = '0;
    else if (tenure_q == TEN_MAX) tenure_d = tenure_q;
    else                          tenure_d = tenure_q + TEN_W'(1);
`endif

    // A sampled DMA_REQ=0 lifts the post-bus-error lockout; a fresh abort below overrides it.
    if (!bus.DMA_REQ) berr_block_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (cool_q != '0)                          cool_d  = cool_q - CD_W'(1);
        else if (bus.DMA_REQ && !berr_block_q)     state_d = REQ;
      end
      REQ: begin
        if (!bus.DMA_REQ)  state_d = IDLE;
        else if (!bus._BG) state_d = WAIT_IDLE;
      end
      WAIT_IDLE: begin
        if (bus_idle_c) begin
          state_d   = OWN;
          granted_d = 1'b1;
        end
      end
      OWN: begin
        if (!bus._BERR) begin
          state_d      = REL;
          bus_err_d    = 1'b1;
          berr_block_d = 1'b1;
        end else if (!bus.DMA_REQ && !bus.CYCLE_ACTIVE) begin
          state_d = REL;
        end
`ifdef TENURE_LIMIT_EN
        else if (tenure_hit_c) begin
          state_d  = REL;
          forced_d = 1'b1;
        end
`endif
      end
      REL: begin
        state_d = IDLE;
`ifdef TENURE_LIMIT_EN
        cool_d   = forced_q ? CD_TENURE : CD_NORMAL;
        forced_d = 1'b0;
`else
        cool_d   = CD_NORMAL;
`endif
      end
      default: state_d = IDLE;
    endcase

    // Outputs follow the state being entered so they change on the transition edge.
    br_d    = !((state_d == REQ) || (state_d == WAIT_IDLE));
    bgack_d = !((state_d == OWN) || (state_d == REL));
    own_d   = (state_d != OWN);
  end
endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Self-checking bench for dma_bus_arbiter: directed scenarios plus randomized traffic vs a reference model.
// Output vectors are printed as {_BR,_BGACK_O,OWN_,GRANTED,BUS_ERR}.
module tb_dma_bus_arbiter;
  logic SCLK = 1'b0;
  logic _RST;

  dma_bus_arbiter_if bus ();

  dma_bus_arbiter dut (
    .SCLK (SCLK),
    ._RST (_RST),
    .bus  (bus)
  );

  always #5 SCLK = ~SCLK;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: bus tenure phases as flags, cooldown as an absolute earliest-request edge.
  int m_cyc = 0;
  int m_next_ok = 0;
  bit m_req, m_wait, m_own, m_rel, m_lock, m_forced, m_granted, m_buserr;
`ifdef TENURE_LIMIT_EN
  int m_own_start = 0;
`endif

  task automatic model_step();
    bit lock_set;
    bit idle;
    lock_set = 1'b0;
    idle = bus._AS_IN && (bus._DSACK_IN == 2'b11) && bus._STERM && bus._BGACK_IN;
    m_cyc++;
    m_granted = 1'b0;
    m_buserr  = 1'b0;
    if (!_RST) begin
      {m_req, m_wait, m_own, m_rel, m_lock, m_forced} = '0;
      m_next_ok = 0;
    end else begin
      if (m_rel) begin
        m_rel = 1'b0;
        m_next_ok = m_cyc + (m_forced ? 4 : 2);
        m_forced = 1'b0;
      end else if (m_own) begin
        if (!bus._BERR) begin
          m_own = 1'b0; m_rel = 1'b1; m_buserr = 1'b1; lock_set = 1'b1;
        end else if (!bus.DMA_REQ && !bus.CYCLE_ACTIVE) begin
          m_own = 1'b0; m_rel = 1'b1;
        end
`ifdef TENURE_LIMIT_EN
        else if ((m_cyc - m_own_start) > 255 && !bus.CYCLE_ACTIVE) begin
          m_own = 1'b0; m_rel = 1'b1; m_forced = 1'b1;
        end
`endif
      end else if (m_wait) begin
        if (idle) begin
          m_wait = 1'b0; m_own = 1'b1; m_granted = 1'b1;
`ifdef TENURE_LIMIT_EN
          m_own_start = m_cyc;
`endif
        end
      end else if (m_req) begin
        if (!bus.DMA_REQ) m_req = 1'b0;
        else if (!bus._BG) begin m_req = 1'b0; m_wait = 1'b1; end
      end else if (bus.DMA_REQ && !m_lock && m_cyc >= m_next_ok) begin
        m_req = 1'b1;
      end
      if (lock_set) m_lock = 1'b1;
      else if (!bus.DMA_REQ) m_lock = 1'b0;
    end
  endtask

  // Inputs are changed only after a falling edge; outputs are read at the next falling edge.
  task automatic step();
    model_step();
    @(posedge SCLK);
    @(negedge SCLK);
  endtask

  function automatic logic [4:0] outs();
    return {bus._BR, bus._BGACK_O, bus.OWN_, bus.GRANTED, bus.BUS_ERR};
  endfunction

  task automatic set_idle_inputs();
    bus.DMA_REQ = 1'b0; bus.CYCLE_ACTIVE = 1'b0; bus._BG = 1'b1; bus._BGACK_IN = 1'b1;
    bus._AS_IN = 1'b1; bus._DSACK_IN = 2'b11; bus._STERM = 1'b1; bus._BERR = 1'b1;
  endtask

  // s = {DMA_REQ, _BG, CYCLE_ACTIVE, _BERR, _AS_IN}
  task automatic apply(input logic [4:0] s);
    bus.DMA_REQ = s[4]; bus._BG = s[3]; bus.CYCLE_ACTIVE = s[2]; bus._BERR = s[1]; bus._AS_IN = s[0];
  endtask

  task automatic do_reset();
    set_idle_inputs();
    _RST = 1'b0;
    step();
    _RST = 1'b1;
  endtask

  task automatic acquire();
    int k;
    k = 0;
    bus.DMA_REQ = 1'b1;
    bus._BG = 1'b0;
    while (bus.OWN_ !== 1'b0 && k < 20) begin step(); k++; end
    n_tests++;
    if (bus.OWN_ !== 1'b0) begin
      n_fail++;
      $display("FAIL acquire: OWN_=%b after %0d cycles, expected 0", bus.OWN_, k);
    end
    bus._BG = 1'b1;
  endtask

  task automatic test_reset();
    logic [4:0] o;
    set_idle_inputs();
    bus.DMA_REQ = 1'b1; bus._BG = 1'b0;
    _RST = 1'b0;
    step();
    o = outs(); n_tests++;
    if (o !== 5'b11100) begin n_fail++; $display("FAIL reset_state: outs=%b expected 11100", o); end
    step();
    o = outs(); n_tests++;
    if (o !== 5'b11100) begin n_fail++; $display("FAIL reset_held: outs=%b expected 11100", o); end
    _RST = 1'b1;
  endtask

  task automatic test_basic_grant();
    logic [4:0] stim [7];
    logic [4:0] expv [7];
    logic [4:0] o;
    stim = '{5'b11011, 5'b11011, 5'b10011, 5'b10011, 5'b11011, 5'b01011, 5'b01011};
    expv = '{5'b01100, 5'b01100, 5'b01100, 5'b10010, 5'b10000, 5'b10100, 5'b11100};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      apply(stim[i]); step();
      o = outs(); n_tests++;
      if (o !== expv[i]) begin n_fail++; $display("FAIL basic_grant step %0d: outs=%b expected %b", i, o, expv[i]); end
    end
  endtask

  task automatic test_busy_bus();
    logic [3:0] m;
    logic [4:0] o;
    do_reset();
    apply(5'b11011); step();
    o = outs(); n_tests++;
    if (o !== 5'b01100) begin n_fail++; $display("FAIL busy_req: outs=%b expected 01100", o); end
    bus._BG = 1'b0;
    for (int i = 0; i < 5; i++) begin
      m = 4'($urandom_range(1, 15));
      bus._AS_IN = !m[0];
      bus._DSACK_IN = m[1] ? 2'($urandom_range(0, 2)) : 2'b11;
      bus._STERM = !m[2];
      bus._BGACK_IN = !m[3];
      step();
      o = outs(); n_tests++;
      if (o !== 5'b01100) begin n_fail++; $display("FAIL busy_wait cycle %0d mask %b: outs=%b expected 01100", i, m, o); end
    end
    bus._AS_IN = 1'b1; bus._DSACK_IN = 2'b11; bus._STERM = 1'b1; bus._BGACK_IN = 1'b1;
    step();
    o = outs(); n_tests++;
    if (o !== 5'b10010) begin n_fail++; $display("FAIL busy_own: outs=%b expected 10010", o); end
  endtask

  task automatic test_release();
    logic [4:0] stim [7];
    logic [4:0] expv [7];
    logic [4:0] o;
    stim = '{5'b01111, 5'b01111, 5'b01111, 5'b01011, 5'b11011, 5'b11011, 5'b11011};
    expv = '{5'b10000, 5'b10000, 5'b10000, 5'b10100, 5'b11100, 5'b11100, 5'b01100};
    do_reset();
    acquire();
    for (int i = 0; i < 7; i++) begin
      apply(stim[i]); step();
      o = outs(); n_tests++;
      if (o !== expv[i]) begin n_fail++; $display("FAIL release step %0d: outs=%b expected %b", i, o, expv[i]); end
    end
  endtask

  task automatic test_bus_error();
    logic [4:0] stim [12];
    logic [4:0] expv [12];
    logic [4:0] o;
    stim = '{5'b11101, 5'b11101, 5'b10100, 5'b10100, 5'b10101, 5'b11101,
             5'b11111, 5'b11011, 5'b11011, 5'b11011, 5'b01011, 5'b11011};
    expv = '{5'b01100, 5'b01100, 5'b01100, 5'b01100, 5'b10010, 5'b10101,
             5'b11100, 5'b11100, 5'b11100, 5'b11100, 5'b11100, 5'b01100};
    do_reset();
    for (int i = 0; i < 12; i++) begin
      apply(stim[i]); step();
      o = outs(); n_tests++;
      if (o !== expv[i]) begin n_fail++; $display("FAIL bus_error step %0d: outs=%b expected %b", i, o, expv[i]); end
    end
  endtask

  task automatic test_reset_mid_own();
    logic [4:0] stim [3];
    logic       rst  [3];
    logic [4:0] expv [3];
    logic [4:0] o;
    do_reset();
    for (int pass = 0; pass < 2; pass++) begin
      // pass 0: reset during normal ownership; pass 1: reset must also clear the bus-error lockout
      stim = '{(pass == 0) ? 5'b11111 : 5'b11101, 5'b11111, 5'b11111};
      rst  = '{1'b1, 1'b0, 1'b1};
      expv = '{(pass == 0) ? 5'b10000 : 5'b10101, 5'b11100, 5'b01100};
      acquire();
      for (int i = 0; i < 3; i++) begin
        apply(stim[i]); _RST = rst[i]; step();
        o = outs(); n_tests++;
        if (o !== expv[i]) begin n_fail++; $display("FAIL reset_mid_own pass %0d step %0d: outs=%b expected %b", pass, i, o, expv[i]); end
      end
    end
  endtask

`ifdef TENURE_LIMIT_EN
  task automatic test_tenure();
    logic [4:0] o;
    do_reset();
    acquire();
    apply(5'b11011);
    for (int i = 1; i <= 255; i++) begin
      step();
      o = outs(); n_tests++;
      if (o !== 5'b10000) begin n_fail++; $display("FAIL tenure_hold cycle %0d: outs=%b expected 10000", i, o); end
    end
    step();
    o = outs(); n_tests++;
    if (o !== 5'b10100) begin n_fail++; $display("FAIL tenure_forced_rel: outs=%b expected 10100", o); end
    for (int i = 0; i < 4; i++) begin
      step();
      o = outs(); n_tests++;
      if (o !== 5'b11100) begin n_fail++; $display("FAIL tenure_cooldown cycle %0d: outs=%b expected 11100", i, o); end
    end
    step();
    o = outs(); n_tests++;
    if (o !== 5'b01100) begin n_fail++; $display("FAIL tenure_rereq: outs=%b expected 01100", o); end
  endtask
`else
  task automatic test_unbounded();
    logic [4:0] o;
    do_reset();
    acquire();
    apply(5'b11011);
    for (int i = 1; i <= 300; i++) begin
      step();
      o = outs(); n_tests++;
      if (o !== 5'b10000) begin n_fail++; $display("FAIL unbounded_hold cycle %0d: outs=%b expected 10000", i, o); end
    end
  endtask
`endif

  task automatic test_random();
    logic [4:0] e, o;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      _RST = ($urandom_range(0, 255) != 0);
      if ($urandom_range(0, 5) == 0) bus.DMA_REQ = ~bus.DMA_REQ;
      bus.CYCLE_ACTIVE = ($urandom_range(0, 2) == 0);
      bus._BG = ($urandom_range(0, 3) == 0);
      bus._AS_IN = ($urandom_range(0, 5) != 0);
      bus._DSACK_IN = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
      bus._STERM = ($urandom_range(0, 7) != 0);
      bus._BGACK_IN = ($urandom_range(0, 7) != 0);
      bus._BERR = ($urandom_range(0, 39) != 0);
      step();
      e = {~(m_req | m_wait), ~(m_own | m_rel), ~m_own, m_granted, m_buserr};
      o = outs();
      n_tests++;
      if (o !== e) begin n_fail++; $display("FAIL random cycle %0d: outs=%b expected %b", i, o, e); end
      n_tests++;
      if ((o[4] === 1'b0 && o[2] === 1'b0) || (o[3] === 1'b1 && o[2] === 1'b0)) begin
        n_fail++; $display("FAIL random_invariant cycle %0d: outs=%b has illegal BR/BGACK/OWN combination", i, o);
      end
    end
    _RST = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    _RST = 1'b0;
    set_idle_inputs();
    test_reset();
    test_basic_grant();
    test_busy_bus();
    test_release();
    test_bus_error();
    test_reset_mid_own();
`ifdef TENURE_LIMIT_EN
    test_tenure();
`else
    test_unbounded();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/dma_bus_arbiter.md
DMA_BUS_ARBITER -- requirements
Module: dma_bus_arbiter

Interface
REQ-001 The block SHALL use exactly one clock and a synchronous, active-low reset: SCLK, _RST.
REQ-002 Ports SHALL be as follows.
- SCLK  in  1  CPU clock; all state changes on its rising edge.
- _RST  in  1  synchronous active-low reset.
- DMA_REQ  in  1  high = the DMA engine needs the bus.
- CYCLE_ACTIVE  in  1  high = a DMA bus cycle is in progress (_AS driven low by this device).
- _BG  in  1  bus grant from the CPU, active low.
- _BGACK_IN  in  1  sampled bus-grant-acknowledge line, active low.
- _AS_IN  in  1  sampled address strobe.
- _DSACK_IN  in  2  sampled dynamic-size acknowledge lines.
- _STERM  in  1  synchronous termination, active low.
- _BERR  in  1  bus error, active low.
- _BR  out  1  bus request, active low.
- _BGACK_O  out  1  bus-grant-acknowledge drive, active low.
- OWN_  out  1  active low; this device is bus master, enables the control and address drivers.
- GRANTED  out  1  single-cycle pulse on entry to OWN.
- BUS_ERR  out  1  single-cycle pulse when a bus error aborts ownership.

Function
REQ-003 All outputs SHALL be registered.
REQ-004 The FSM SHALL have five states: IDLE, REQ, WAIT_IDLE, OWN, REL.
REQ-005 IDLE: _BR=1, _BGACK_O=1, OWN_=1. If DMA_REQ=1 and the block is not blocked (REQ-012, REQ-014), the FSM SHALL go to REQ and drive _BR=0 from that same edge.
REQ-006 REQ: _BR=0.
- _BG=0 sampled: go to WAIT_IDLE.
- DMA_REQ=0 before the grant: return to IDLE with _BR=1.
- If both occur on the same edge, the DMA_REQ=0 case SHALL win.
REQ-007 WAIT_IDLE: _BR stays 0. The FSM SHALL go to OWN on the first edge where all of these hold: _AS_IN=1, _DSACK_IN=2'b11, _STERM=1, _BGACK_IN=1. Latency from _BG low to OWN SHALL be at least 1 cycle; there is no upper bound.
REQ-008 Entering OWN on the same edge SHALL set _BGACK_O=0, OWN_=0, _BR=1 and GRANTED=1 for one cycle.
REQ-009 OWN SHALL be held while DMA_REQ=1 or CYCLE_ACTIVE=1. When both are 0, the FSM SHALL go to REL.
REQ-010 Release ordering is fixed.
- In REL: OWN_=1, _BGACK_O=0.
- Next edge: go to IDLE with _BGACK_O=1.
- Drivers are therefore tri-stated one full cycle before _BGACK is released.
REQ-011 If _BERR=0 is sampled in OWN, the FSM SHALL go to REL on that edge regardless of CYCLE_ACTIVE or DMA_REQ, and SHALL pulse BUS_ERR for one cycle.
REQ-012 After a bus-error abort, no new request SHALL be made until DMA_REQ has been sampled 0 at least once.
REQ-013 If _BERR=0 occurs in REQ or WAIT_IDLE, it SHALL be ignored.
REQ-014 In IDLE, a cooldown counter SHALL block re-request for 2 cycles after leaving REL.
REQ-015 _BR=0 and OWN_=0 SHALL never be asserted simultaneously. _BGACK_O=1 with OWN_=0 SHALL never occur.

Reset
REQ-016 When _RST=0 is sampled, the next edge SHALL put the FSM in IDLE with _BR=1, _BGACK_O=1, OWN_=1, GRANTED=0, BUS_ERR=0. All counters and the bus-error block SHALL be cleared. This SHALL apply in every state, including mid-OWN, and there is no orderly release sequence on reset.

Configuration
REQ-017 Macro TENURE_LIMIT_EN, when defined, SHALL compile in an 8-bit tenure counter.
- The counter clears on entry to OWN and increments each cycle in OWN, saturating at 255.
- When the count is 255 and CYCLE_ACTIVE=0, the FSM SHALL go to REL even if DMA_REQ=1.
- After that forced release, the IDLE cooldown SHALL be 4 cycles instead of 2.
REQ-018 Without TENURE_LIMIT_EN, the counter SHALL be absent and ownership SHALL be unbounded.

Verification
REQ-019 Basic grant: DMA_REQ=1 with the bus idle, _BG=0 two cycles after _BR falls. Required:
- _BR=0 one edge after DMA_REQ.
- OWN_=0 and _BGACK_O=0 one edge after _BG is sampled low.
- GRANTED pulses once.
- _BR=1 at the same edge.
REQ-020 Busy bus: _BG=0 while _AS_IN=0 for 5 cycles. Required: WAIT_IDLE is held for 5 cycles, and OWN is entered on the edge after _AS_IN=1.
REQ-021 Release: in OWN, drop DMA_REQ while CYCLE_ACTIVE=1 for 3 cycles. Required:
- OWN is held 3 cycles.
- Then OWN_=1 with _BGACK_O=0 for 1 cycle.
- Then _BGACK_O=1.
- No _BR for 2 cycles even with DMA_REQ=1 re-asserted.
REQ-022 Bus error: _BERR=0 in OWN with CYCLE_ACTIVE=1. Required:
- REL on the next edge and BUS_ERR pulses.
- DMA_REQ held at 1 produces no _BR until DMA_REQ toggles 0 then 1.
REQ-023 Reset mid-OWN: _RST=0 for 1 cycle. Required: _BR=1, _BGACK_O=1, OWN_=1 at the next edge.
REQ-024 TENURE_LIMIT_EN defined, DMA_REQ=1 held. Required:
- Forced REL after 255 OWN cycles, with OWN_=1 at count 255 plus one edge.
- The next _BR=0 occurs 4 cycles after IDLE entry.
